// File: rtl/id_ex_stage.sv
// RV32I OP/OP-IMM decode, operand forwarding and ID/EX pipeline register.
// Registered operands and ALU controls are presented under a valid/ready handshake, with flush.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_ex_fwd_we,
  input  logic [4:0]      i_ex_fwd_rd,
  input  logic [XLEN-1:0] i_ex_fwd_data,
  input  logic            i_wb_fwd_we,
  input  logic [4:0]      i_wb_fwd_rd,
  input  logic [XLEN-1:0] i_wb_fwd_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_dataa,
  output logic [XLEN-1:0] o_datab,
  output logic [2:0]      o_funct3,
  output logic            o_sub_sra,
  output logic [4:0]      o_rd,
  output logic            o_rd_we,
  output logic            o_illegal
);

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLT  = 3'b001,
    ALU_SLTU = 3'b010,
    ALU_AND  = 3'b011,
    ALU_OR   = 3'b100,
    ALU_XOR  = 3'b101,
    ALU_SLL  = 3'b110,
    ALU_SRL  = 3'b111
  } alu_op_e;

  logic [6:0]      opcode;
  logic [2:0]      rv_funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  alu_op_e         dec_funct3;
  logic [XLEN-1:0] dec_datab;
  logic            dec_sub_sra;
  logic            dec_illegal;
  logic            dec_rd_we;
  logic            capture;

  assign opcode    = i_instr[6:0];
  assign rd_idx    = i_instr[11:7];
  assign rv_funct3 = i_instr[14:12];
  assign rs1_idx   = i_instr[19:15];
  assign rs2_idx   = i_instr[24:20];
  assign funct7    = i_instr[31:25];

  // EX beats WB beats register file; x0 reads as zero even with forwarding disabled.
  function automatic logic [XLEN-1:0] resolve(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_we,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_we,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] val;
    val = rf_data;
    if (idx == 5'd0) begin
      val = '0;
    end else if (FWD_EN) begin
      if (ex_we && (ex_rd == idx)) begin
        val = ex_data;
      end else if (wb_we && (wb_rd == idx)) begin
        val = wb_data;
      end
    end
    return val;
  endfunction

  always_comb begin
    rs1_val = resolve(rs1_idx, i_rs1_data, i_ex_fwd_we, i_ex_fwd_rd, i_ex_fwd_data,
                      i_wb_fwd_we, i_wb_fwd_rd, i_wb_fwd_data);
    rs2_val = resolve(rs2_idx, i_rs2_data, i_ex_fwd_we, i_ex_fwd_rd, i_ex_fwd_data,
                      i_wb_fwd_we, i_wb_fwd_rd, i_wb_fwd_data);
  end

  always_comb begin
    unique case (rv_funct3)
      3'b000:  dec_funct3 = ALU_ADD;
      3'b010:  dec_funct3 = ALU_SLT;
      3'b011:  dec_funct3 = ALU_SLTU;
      3'b111:  dec_funct3 = ALU_AND;
      3'b110:  dec_funct3 = ALU_OR;
      3'b100:  dec_funct3 = ALU_XOR;
      3'b001:  dec_funct3 = ALU_SLL;
      default: dec_funct3 = ALU_SRL;
    endcase
  end

  always_comb begin
    dec_datab   = rs2_val;
    dec_sub_sra = 1'b0;
    dec_illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        dec_datab = rs2_val;
        if (funct7 == 7'b0000000) begin
          dec_sub_sra = 1'b0;
        end else if ((funct7 == 7'b0100000) &&
                     ((rv_funct3 == 3'b000) || (rv_funct3 == 3'b101))) begin
          dec_sub_sra = i_instr[30];
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_datab = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
        if (rv_funct3 == 3'b001) begin
          dec_datab   = {{(XLEN-5){1'b0}}, i_instr[24:20]};
          dec_illegal = (funct7 != 7'b0000000);
        end else if (rv_funct3 == 3'b101) begin
          dec_datab   = {{(XLEN-5){1'b0}}, i_instr[24:20]};
          dec_sub_sra = i_instr[30];
          dec_illegal = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign dec_rd_we = ~dec_illegal & (rd_idx != 5'd0);
  assign o_ready   = ~o_valid | i_ready;
  assign capture   = i_valid & o_ready;

  // Flush only needs to kill valid and writeback; data registers may stay stale.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_dataa   <= '0;
      o_datab   <= '0;
      o_funct3  <= '0;
      o_sub_sra <= 1'b0;
      o_rd      <= '0;
      o_rd_we   <= 1'b0;
      o_illegal <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_rd_we <= 1'b0;
    end else if (o_ready) begin
      o_valid <= i_valid;
      if (capture) begin
        o_dataa   <= rs1_val;
        o_datab   <= dec_datab;
        o_funct3  <= dec_illegal ? ALU_ADD : dec_funct3;
        o_sub_sra <= dec_illegal ? 1'b0 : dec_sub_sra;
        o_rd      <= rd_idx;
        o_rd_we   <= dec_rd_we;
        o_illegal <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, stall, flush and reset.
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_we;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] dataa;
  logic [31:0] datab;
  logic [2:0]  funct3;
  logic        sub_sra;
  logic [4:0]  rd;
  logic        rd_we;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (in_valid),
    .o_ready      (out_ready),
    .i_instr      (instr),
    .i_rs1_data   (rs1_data),
    .i_rs2_data   (rs2_data),
    .i_ex_fwd_we  (ex_we),
    .i_ex_fwd_rd  (ex_rd),
    .i_ex_fwd_data(ex_data),
    .i_wb_fwd_we  (wb_we),
    .i_wb_fwd_rd  (wb_rd),
    .i_wb_fwd_data(wb_data),
    .i_flush      (flush),
    .o_valid      (out_valid),
    .i_ready      (in_ready),
    .o_dataa      (dataa),
    .o_datab      (datab),
    .o_funct3     (funct3),
    .o_sub_sra    (sub_sra),
    .o_rd         (rd),
    .o_rd_we      (rd_we),
    .o_illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"},   {31'd0, out_valid}, 32'd0);
    chk({tag, " dataa"},   dataa, 32'd0);
    chk({tag, " datab"},   datab, 32'd0);
    chk({tag, " funct3"},  {29'd0, funct3}, 32'd0);
    chk({tag, " sub_sra"}, {31'd0, sub_sra}, 32'd0);
    chk({tag, " rd"},      {27'd0, rd}, 32'd0);
    chk({tag, " rd_we"},   {31'd0, rd_we}, 32'd0);
    chk({tag, " illegal"}, {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; rs1_data = '0; rs2_data = '0;
    ex_we = 1'b0; ex_rd = '0; ex_data = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; in_ready = 1'b1;
    step();
    step();
    chk_zero("reset");
    chk("reset ready", {31'd0, out_ready}, 32'd1);

    // add x3,x1,x2
    rst = 1'b0; in_valid = 1'b1; instr = 32'h002081B3; rs1_data = 32'd5; rs2_data = 32'd7;
    step();
    chk("add valid",   {31'd0, out_valid}, 32'd1);
    chk("add dataa",   dataa, 32'd5);
    chk("add datab",   datab, 32'd7);
    chk("add funct3",  {29'd0, funct3}, 32'd0);
    chk("add sub_sra", {31'd0, sub_sra}, 32'd0);
    chk("add rd",      {27'd0, rd}, 32'd3);
    chk("add rd_we",   {31'd0, rd_we}, 32'd1);
    chk("add illegal", {31'd0, illegal}, 32'd0);

    // sub with EX and WB both matching rs1: EX wins
    instr = 32'h402081B3; rs1_data = 32'h30;
    ex_we = 1'b1; ex_rd = 5'd1; ex_data = 32'h10;
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h20;
    step();
    chk("sub ex dataa",   dataa, 32'h10);
    chk("sub ex datab",   datab, 32'd7);
    chk("sub ex sub_sra", {31'd0, sub_sra}, 32'd1);
    chk("sub ex funct3",  {29'd0, funct3}, 32'd0);

    ex_we = 1'b0;
    step();
    chk("sub wb dataa", dataa, 32'h20);

    // addi x5,x0,-1 with an EX write to x0 that must not forward
    instr = 32'hFFF00293; rs1_data = 32'hDEAD; wb_we = 1'b0;
    ex_we = 1'b1; ex_rd = 5'd0; ex_data = 32'h55;
    step();
    chk("addi dataa",   dataa, 32'd0);
    chk("addi datab",   datab, 32'hFFFFFFFF);
    chk("addi funct3",  {29'd0, funct3}, 32'd0);
    chk("addi sub_sra", {31'd0, sub_sra}, 32'd0);
    chk("addi rd",      {27'd0, rd}, 32'd5);
    chk("addi rd_we",   {31'd0, rd_we}, 32'd1);

    // srai x6,x7,4
    instr = 32'h4043D313; rs1_data = 32'h99; ex_we = 1'b0;
    step();
    chk("srai dataa",   dataa, 32'h99);
    chk("srai datab",   datab, 32'd4);
    chk("srai funct3",  {29'd0, funct3}, 32'd7);
    chk("srai sub_sra", {31'd0, sub_sra}, 32'd1);
    chk("srai rd",      {27'd0, rd}, 32'd6);

    // stall for three cycles while inputs churn
    in_ready = 1'b0; instr = 32'h002081B3; rs1_data = 32'h1234; rs2_data = 32'h5678;
    ex_we = 1'b1; ex_rd = 5'd1; ex_data = 32'hAAAA;
    #1;
    chk("stall ready", {31'd0, out_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      ex_data = ex_data + 32'd1;
      chk("stall valid",  {31'd0, out_valid}, 32'd1);
      chk("stall dataa",  dataa, 32'h99);
      chk("stall datab",  datab, 32'd4);
      chk("stall funct3", {29'd0, funct3}, 32'd7);
      chk("stall ready",  {31'd0, out_ready}, 32'd0);
    end

    // release: back-to-back capture of add
    in_ready = 1'b1; ex_we = 1'b0; rs1_data = 32'd5; rs2_data = 32'd7;
    #1;
    chk("release ready", {31'd0, out_ready}, 32'd1);
    step();
    chk("b2b valid",  {31'd0, out_valid}, 32'd1);
    chk("b2b dataa",  dataa, 32'd5);
    chk("b2b datab",  datab, 32'd7);
    chk("b2b funct3", {29'd0, funct3}, 32'd0);

    // xor and sra funct3 mapping
    instr = 32'h0020C1B3;
    step();
    chk("xor funct3", {29'd0, funct3}, 32'd5);
    instr = 32'h4020D1B3;
    step();
    chk("sra funct3",  {29'd0, funct3}, 32'd7);
    chk("sra sub_sra", {31'd0, sub_sra}, 32'd1);

    // flush discards held and incoming instruction
    flush = 1'b1; instr = 32'h002081B3;
    step();
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    chk("flush rd_we", {31'd0, rd_we}, 32'd0);
    flush = 1'b0;

    // reset during a stall
    step();
    chk("recap valid", {31'd0, out_valid}, 32'd1);
    in_ready = 1'b0;
    step();
    chk("midstall valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    step();
    chk_zero("midrst");
    rst = 1'b0; in_ready = 1'b1;

    // load opcode is illegal
    instr = 32'h00002003;
    step();
    chk("load valid",   {31'd0, out_valid}, 32'd1);
    chk("load illegal", {31'd0, illegal}, 32'd1);
    chk("load rd_we",   {31'd0, rd_we}, 32'd0);
    chk("load funct3",  {29'd0, funct3}, 32'd0);
    chk("load sub_sra", {31'd0, sub_sra}, 32'd0);

    // OP with funct7 0000001 is illegal
    instr = 32'h022081B3;
    step();
    chk("f7 illegal", {31'd0, illegal}, 32'd1);
    chk("f7 rd_we",   {31'd0, rd_we}, 32'd0);

    // add to x0: legal, no writeback
    instr = 32'h00208033;
    step();
    chk("x0 illegal", {31'd0, illegal}, 32'd0);
    chk("x0 rd_we",   {31'd0, rd_we}, 32'd0);

    // consumed with nothing new: valid drops
    in_valid = 1'b0;
    step();
    chk("drain valid", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage and ID/EX pipeline register; sits directly upstream of the register-to-register ALU.
- Takes a RV32I OP/OP-IMM instruction plus register-file read data.
- Resolves forwarding and maps RISC-V funct3 onto the ALU's internal funct3 encoding.
- Presents registered operands and controls to the ALU under a valid/ready handshake, with stall and flush.

Parameters:
XLEN, 32, datapath width; only 32 supported.
FWD_EN, 1, 1 = forwarding muxes present; 0 = operands taken from register file only.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  synchronous reset, active-high
i_valid  input  1  upstream instruction valid
o_ready  output  1  stage can accept an instruction this cycle
i_instr  input  32  instruction word
i_rs1_data  input  32  register-file read of rs1
i_rs2_data  input  32  register-file read of rs2
i_ex_fwd_we  input  1  EX-stage result will write rd
i_ex_fwd_rd  input  5  EX-stage destination
i_ex_fwd_data  input  32  EX-stage ALU result
i_wb_fwd_we  input  1  MEM/WB write enable
i_wb_fwd_rd  input  5  MEM/WB destination
i_wb_fwd_data  input  32  MEM/WB write data
i_flush  input  1  kill held and incoming instruction
o_valid  output  1  outputs hold a valid instruction
i_ready  input  1  ALU/EX stage consumes this cycle
o_dataa  output  32  ALU operand A
o_datab  output  32  ALU operand B (rs2 or immediate)
o_funct3  output  3  ALU funct3 (internal encoding)
o_sub_sra  output  1  ALU sub/sra modifier
o_rd  output  5  destination register
o_rd_we  output  1  writeback enable
o_illegal  output  1  instruction not OP/OP-IMM or bad funct7

Behaviour:
- Reset (i_rst high at clock edge): o_valid=0, o_dataa=0, o_datab=0, o_funct3=0, o_sub_sra=0, o_rd=0, o_rd_we=0, o_illegal=0. Reset overrides flush and capture.
- Handshake:
  - o_ready = ~o_valid | i_ready (combinational).
  - Capture when i_valid & o_ready; latency 1 cycle from capture to o_valid.
  - If o_valid & ~i_ready, all outputs hold stable.
  - If o_valid & i_ready & ~i_valid, o_valid drops to 0 next cycle.
- Flush: i_flush forces o_valid=0 and o_rd_we=0 next cycle, regardless of i_valid/i_ready. An incoming instruction in the same cycle is discarded. Data outputs may keep stale values.
- Forwarding at capture, per source (rs1=instr[19:15], rs2=instr[24:20]):
  - Priority: EX (i_ex_fwd_we & rd match), then WB, then register file.
  - rd=0 never matches; a source index of 0 always yields 0.
  - Operands are latched once; no re-forwarding while stalled.
  - FWD_EN=0: register file only, but x0 is still 0.
- Decode for OP (opcode 0110011) and OP-IMM (opcode 0010011):
  - RISC-V funct3 to ALU funct3: 000→000 add, 010→001 slt, 011→010 sltu, 111→011 and, 110→100 or, 100→101 xor, 001→110 sll, 101→111 srl.
  - OP: o_datab=rs2 value. o_sub_sra=instr[30] for funct3 000/101, else 0. funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - OP-IMM: o_datab=sign-extended instr[31:20]. For funct3 001/101, o_datab = zero-extended instr[24:20] and o_sub_sra=instr[30]. imm[11:5] must be 0000000 (001) or 0000000/0100000 (101). Otherwise o_sub_sra=0 (ADDI never subtracts).
  - o_sub_sra=1 with funct3 111 means arithmetic right shift; with 000 means subtract.
- Illegal (other opcode or bad funct7): captured with o_illegal=1, o_rd_we=0, o_funct3=000, o_sub_sra=0.
- Legal: o_rd=instr[11:7]; o_rd_we=1 if rd≠0, else 0.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, no forwarding, i_ready=1 → next cycle o_valid=1, dataa=5, datab=7, funct3=000, sub_sra=0, rd=3, rd_we=1.
- sub 0x402081B3 with EX fwd rd=1 data=0x10 and WB fwd rd=1 data=0x20, rs1 regfile=0x30 → dataa=0x10, sub_sra=1; repeat with only WB match → dataa=0x20.
- addi x5,x0,-1 (0xFFF00293), i_rs1_data=0xDEAD, EX fwd rd=0 → dataa=0, datab=0xFFFFFFFF, funct3=000, sub_sra=0; srai x6,x7,4 (0x4043D313) → datab=4, funct3=111, sub_sra=1.
- Hold i_ready=0 for 3 cycles after capture while changing i_instr/forward inputs → outputs unchanged, o_ready=0; raise i_ready with i_valid=1 → back-to-back capture, o_valid stays 1.
- i_flush with o_valid=1 and i_valid=1 → next cycle o_valid=0, rd_we=0; i_rst asserted mid-stall → all outputs zero next cycle.
- Load opcode 0x00002003 or OP funct7 0x01 → o_illegal=1, rd_we=0; add with rd=0 → rd_we=0, illegal=0.
